// File: rtl/ready_wait_controller_pkg.sv
// Shared types and helpers for the 8088 READY wait-state controller.
// Holds the FSM state type, the overlapping-decode wait reduction and parameter limits.
package ready_pkg;

   localparam int unsigned MaxSources   = 8;
   localparam int unsigned MaxWaitWidth = 16;

   typedef enum logic [1:0] {
      StIdle,
      StMinWait,
      StPoll,
      StRelease
   } state_e;

   // Largest minimum wait among the selected sources, unsigned.
   function automatic int unsigned max_wait(input logic [MaxSources-1:0]              sel,
                                            input logic [MaxSources*MaxWaitWidth-1:0] waits);
      int unsigned m;
      m = 0;
      for (int unsigned i = 0; i < MaxSources; i++) begin
         if (sel[i] && (32'(waits[i*MaxWaitWidth +: MaxWaitWidth]) > m)) begin
            m = 32'(waits[i*MaxWaitWidth +: MaxWaitWidth]);
         end
      end
      return m;
   endfunction

   function automatic bit params_ok(input int unsigned num_sources,
                                    input int unsigned wait_width,
                                    input int unsigned timeout_cycles,
                                    input int unsigned timeout_width);
      return (num_sources >= 1) && (num_sources <= MaxSources) &&
             (wait_width >= 1) && (wait_width <= MaxWaitWidth) &&
             (timeout_width >= 1) && (timeout_width < 32) &&
             (longint'(timeout_cycles) < (longint'(1) << timeout_width));
   endfunction

endpackage

// File: rtl/ready_wait_controller_source_combine.sv
// Reduces the selected sources to one combined ready (AND) and one minimum wait (max).
// Purely combinational.
module ready_source_combine
   import ready_pkg::*;
#(
   parameter int unsigned NumSources = 4,
   parameter int unsigned WaitWidth  = 4
) (
   input  logic [NumSources-1:0]           sel_i,
   input  logic [NumSources-1:0]           ready_i,
   input  logic [NumSources*WaitWidth-1:0] min_wait_i,
   output logic                            ready_o,
   output logic [WaitWidth-1:0]            wait_o
);

   logic [MaxSources-1:0]              sel_ext;
   logic [MaxSources*MaxWaitWidth-1:0] waits_ext;

   always_comb begin
      sel_ext   = '0;
      waits_ext = '0;
      for (int unsigned i = 0; i < NumSources; i++) begin
         sel_ext[i] = sel_i[i];
         waits_ext[i*MaxWaitWidth +: WaitWidth] = min_wait_i[i*WaitWidth +: WaitWidth];
      end
   end

   // Unselected sources count as ready.
   assign ready_o = &(ready_i | ~sel_i);
   assign wait_o  = WaitWidth'(max_wait(sel_ext, waits_ext));

endmodule

// File: rtl/ready_wait_controller.sv
// CPU READY generator: per-source minimum waits, two-phase READY sync and a POLL watchdog.
// RDY moves only on CPU falling edges; the sync flop Q1 only on CPU rising edges.
module ready_wait_controller
   import ready_pkg::*;
#(
   parameter int unsigned NUM_SOURCES    = 4,
   parameter int unsigned WAIT_WIDTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned TIMEOUT_WIDTH  = 8
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              cpu_clock_posedge,
   input  logic                              cpu_clock_negedge,
   input  logic                              cycle_start,
   input  logic                              cycle_end,
   input  logic                              INTA_N,
   input  logic [NUM_SOURCES-1:0]            source_select,
   input  logic [NUM_SOURCES-1:0]            source_ready,
   input  logic [NUM_SOURCES*WAIT_WIDTH-1:0] min_wait,
   output logic                              RDY,
   output logic                              busy,
   output logic                              timeout
);

   if (!params_ok(NUM_SOURCES, WAIT_WIDTH, TIMEOUT_CYCLES, TIMEOUT_WIDTH)) begin : g_param_check
      $error("ready_wait_controller: illegal parameter combination");
   end

   localparam logic [TIMEOUT_WIDTH-1:0] TimeoutLimit = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
   localparam bit                       WatchdogEn   = (TIMEOUT_CYCLES != 0);

   state_e                   state_q, state_d;
   logic [NUM_SOURCES-1:0]   sel_q, sel_d, comb_sel;
   logic [WAIT_WIDTH-1:0]    wait_cnt_q, wait_cnt_d, comb_wait;
   logic [TIMEOUT_WIDTH-1:0] to_cnt_q, to_cnt_d;
   logic                     q1_q, q1_d;
   logic                     rdy_q, rdy_d;
   logic                     forced_q, forced_d;
   logic                     timeout_q, timeout_d;
   logic                     comb_ready, d_bit, go_idle;

   // In IDLE the live decode feeds the wait reduction; afterwards the latched select does.
   assign comb_sel = (state_q == StIdle) ? source_select : sel_q;

   ready_source_combine #(
      .NumSources (NUM_SOURCES),
      .WaitWidth  (WAIT_WIDTH)
   ) u_combine (
      .sel_i      (comb_sel),
      .ready_i    (source_ready),
      .min_wait_i (min_wait),
      .ready_o    (comb_ready),
      .wait_o     (comb_wait)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         sel_q      <= '0;
         wait_cnt_q <= '0;
         to_cnt_q   <= '0;
         q1_q       <= 1'b0;
         rdy_q      <= 1'b0;
         forced_q   <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         wait_cnt_q <= wait_cnt_d;
         to_cnt_q   <= to_cnt_d;
         q1_q       <= q1_d;
         rdy_q      <= rdy_d;
         forced_q   <= forced_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      wait_cnt_d = wait_cnt_q;
      to_cnt_d   = to_cnt_q;
      q1_d       = q1_q;
      rdy_d      = rdy_q;
      forced_d   = forced_q;
      timeout_d  = 1'b0;
      go_idle    = 1'b0;

      if (cpu_clock_posedge) q1_d = d_bit;
      if (cpu_clock_negedge) rdy_d = (state_q == StPoll) ? (d_bit & q1_q) : d_bit;

      unique case (state_q)
         StIdle: begin
            if (cycle_start && INTA_N && (|source_select)) begin
               sel_d = source_select;
               if (comb_wait == '0) begin
                  state_d = StPoll;
               end else begin
                  wait_cnt_d = comb_wait;
                  state_d    = StMinWait;
               end
            end
         end
         StMinWait: begin
            if (cycle_end) begin
               go_idle = 1'b1;
            end else if (cpu_clock_posedge) begin
               wait_cnt_d = wait_cnt_q - 1'b1;
               if (wait_cnt_q == WAIT_WIDTH'(1)) state_d = StPoll;
            end
         end
         StPoll: begin
            if (cycle_end) begin
               go_idle = 1'b1;
            end else begin
               if (cpu_clock_posedge && WatchdogEn && !forced_q) begin
                  to_cnt_d = to_cnt_q + 1'b1;
                  if (to_cnt_d == TimeoutLimit) begin
                     timeout_d = 1'b1;
                     forced_d  = 1'b1;
                     q1_d      = 1'b1;
                  end
               end
               if (cpu_clock_negedge && rdy_d) state_d = StRelease;
            end
         end
         StRelease: begin
            if (cycle_end) go_idle = 1'b1;
         end
         default: state_d = StIdle;
      endcase

      // An abort wins over a same-clock watchdog expiry.
      if (go_idle) begin
         state_d    = StIdle;
         sel_d      = '0;
         wait_cnt_d = '0;
         to_cnt_d   = '0;
         forced_d   = 1'b0;
         timeout_d  = 1'b0;
      end
   end

   always_comb begin
      d_bit = 1'b1;
      busy  = (state_q != StIdle);
      unique case (state_q)
         StIdle:    d_bit = 1'b1;
         StMinWait: d_bit = 1'b0;
         StPoll:    d_bit = comb_ready | forced_q;
         StRelease: d_bit = 1'b1;
         default:   d_bit = 1'b1;
      endcase
   end

   assign RDY     = rdy_q;
   assign timeout = timeout_q;

endmodule

// File: doc/ready_wait_controller.md
Name: ready_wait_controller

Overview:
- Parametrised CPU READY generator for the 8088 bus. It is the successor to the single-source video/sound/ext READY AND.
- Accepts NUM_SOURCES ready-capable slaves. Each slave has a programmable minimum wait-state count.
- Keeps the posedge/negedge two-stage READY synchronisation, adds a timeout watchdog, and lets INTA / unselected cycles bypass waiting.
- Sits between the address decoder / slave peripherals and the CPU RDY input.

Parameters:
- NUM_SOURCES, 4, number of ready-capable slaves (1..8).
- WAIT_WIDTH, 4, width of each per-source minimum wait-state count.
- TIMEOUT_CYCLES, 64, CPU clock periods allowed in POLL before a forced release; 0 disables the watchdog.
- TIMEOUT_WIDTH, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_clock_posedge  in  1  one-clock enable marking the CPU clock rising edge.
- cpu_clock_negedge  in  1  one-clock enable marking the CPU clock falling edge.
- cycle_start  in  1  one-clock pulse, coincident with cpu_clock_posedge, at the end of T1.
- cycle_end  in  1  one-clock pulse at T4 (end of the bus cycle).
- INTA_N  in  1  interrupt acknowledge, active low.
- source_select  in  NUM_SOURCES  decoder hit per source; sampled at cycle_start.
- source_ready  in  NUM_SOURCES  per-source ready (asynchronous to the CPU clock phase).
- min_wait  in  NUM_SOURCES*WAIT_WIDTH  packed minimum wait states; source i is at bits [i*WAIT_WIDTH +: WAIT_WIDTH].
- RDY  out  1  registered ready to the CPU.
- busy  out  1  high while not in IDLE.
- timeout  out  1  one-clock pulse when the watchdog forces a release.

Behaviour:
- Reset values: RDY=0, busy=0, timeout=0. All internal state is cleared: state=IDLE, sel latch=0, counters=0, Q1=0.
- RDY updates only on clocks with cpu_clock_negedge; it holds otherwise. Q1 updates only on cpu_clock_posedge.
- IDLE: D=1 and RDY goes to 1 at the first negedge after reset. On cycle_start:
  - If INTA_N=0 or source_select==0: bypass. RDY stays 1 and the state stays IDLE.
  - Otherwise latch sel=source_select and W = max of min_wait over the selected bits (unsigned). The combined ready R = AND of source_ready over the latched sel bits.
  - If W==0, go to POLL; else load the counter with W and go to MIN_WAIT.
- MIN_WAIT: D=0. RDY falls at the first negedge after cycle_start. The counter decrements on each cpu_clock_posedge; on reaching 0, go to POLL.
- POLL: D=R.
  - Q1<=D on posedge. RDY<=D&Q1 on negedge, so R must be seen high at a posedge and still high at the following negedge.
  - When RDY is set to 1, go to RELEASE.
  - The timeout counter increments on each posedge in POLL. When it equals TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0): pulse timeout, force D=1 and Q1=1, and RDY=1 at the next negedge.
- RELEASE: RDY=1. On cycle_end go to IDLE and clear sel and counters.
- Latency: with W=k and R already high, RDY is low for exactly k+1 CPU clock periods (k minimum waits plus one sync period).
- W==0 with R high at cycle_start: RDY stays high; no wait is inserted. This matches legacy zero-wait behaviour.
- Simultaneous events:
  - cycle_start while busy: ignored.
  - cycle_end in MIN_WAIT or POLL: abort to IDLE with RDY=1 at the next negedge; no timeout pulse.
  - R dropping after RDY=1: no effect.
  - Reset mid-operation: immediate return to the reset values.
- Multiple select bits (overlapping decode) use the AND of readies and the max wait, as stated above.

Decomposition:
- Package ready_pkg:
  - state enum (IDLE, MIN_WAIT, POLL, RELEASE);
  - function max_wait(select, packed waits);
  - localparam checks (NUM_SOURCES range, TIMEOUT_CYCLES < 2**TIMEOUT_WIDTH).
- Sub-module ready_source_combine: purely combinational. Reduces sel/source_ready/min_wait to R and W; instantiated once.

Test Plan:
- Reset mid-POLL -> RDY=0 and busy=0 immediately; RDY=1 at the first negedge after reset deasserts.
- Source 1 selected, min_wait[1]=3, ready held high -> RDY low for exactly 4 CPU periods, then 1; busy clears on cycle_end.
- INTA_N=0 with source_select=4'b0001 and min_wait=5 -> RDY never drops; busy stays 0.
- Sources 0 and 2 selected, waits 2 and 6, source 2 ready pulsed high only across a posedge but low at the following negedge, then held high -> W=6 used; the glitch is rejected; release follows the second sample.
- TIMEOUT_CYCLES=8, selected source never ready -> timeout pulses once after 8 posedges in POLL; RDY=1 at the next negedge; state reaches RELEASE.
- TIMEOUT_CYCLES=0, source never ready for 300 periods, then cycle_end -> no timeout pulse; returns to IDLE with RDY=1.
